// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped lookup/refill controller.
// Provides the FSM state enum, AXI encodings and an AXI size helper.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_RDATA,
        S_RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE encoding: log2 of the bytes per beat
    function automatic logic [2:0] axi_size(input int bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/cache_valid_array.sv
// Per-line valid bits for the direct-mapped cache.
// Ports: clk/reset_n; flush clears all; wr_en/wr_idx/wr_val set or clear one line;
// rd_idx/rd_val combinational read.
module cache_valid_array #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_val,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_val
);

    logic [NUM_LINES-1:0] valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_val;
        end
    end

    assign rd_val = valid[rd_idx];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-only direct-mapped lookup/refill controller in front of cache_way.
// Ports: CPU request/response, flush, cache_way data+tag port, AXI4 AR/R read channels.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int CACHE_WAY_ADDR_WIDTH      = 7,
    parameter int CACHE_WAY_DATA_WIDTH      = 32,
    parameter int CACHE_WAY_DATA_SIZE_BYTES = 4,
    parameter int CACHE_WAY_TAG_WIDTH       = 4,
    parameter int LINE_WORDS                = 4
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              i_cpu_req_valid,
    output logic                                              o_cpu_req_ready,
    input  logic [CACHE_WAY_ADDR_WIDTH+CACHE_WAY_TAG_WIDTH-1:0] i_cpu_req_addr,
    output logic                                              o_cpu_rsp_valid,
    output logic [CACHE_WAY_DATA_WIDTH-1:0]                   o_cpu_rsp_data,
    output logic                                              o_cpu_rsp_err,
    input  logic                                              i_flush,
    output logic [CACHE_WAY_ADDR_WIDTH-1:0]                   o_cache_way_addr,
    output logic                                              o_cache_way_wen,
    output logic [CACHE_WAY_DATA_SIZE_BYTES-1:0]              o_cache_way_ben,
    output logic [CACHE_WAY_DATA_WIDTH-1:0]                   o_cache_way_data,
    input  logic [CACHE_WAY_DATA_WIDTH-1:0]                   i_cache_way_data,
    output logic                                              o_tag_wen,
    output logic [CACHE_WAY_TAG_WIDTH-1:0]                    o_tag_data,
    input  logic [CACHE_WAY_TAG_WIDTH-1:0]                    i_tag_data,
    output logic [CACHE_WAY_ADDR_WIDTH+CACHE_WAY_TAG_WIDTH-1:0] o_axi_araddr,
    output logic [7:0]                                        o_axi_arlen,
    output logic [2:0]                                        o_axi_arsize,
    output logic [1:0]                                        o_axi_arburst,
    output logic                                              o_axi_arvalid,
    input  logic                                              i_axi_arready,
    input  logic                                              i_axi_rvalid,
    output logic                                              o_axi_rready,
    input  logic [CACHE_WAY_DATA_WIDTH-1:0]                   i_axi_rdata,
    input  logic [1:0]                                        i_axi_rresp,
    input  logic                                              i_axi_rlast
);

    localparam int ADDR_W    = CACHE_WAY_ADDR_WIDTH;
    localparam int TAG_W     = CACHE_WAY_TAG_WIDTH;
    localparam int BYTES     = CACHE_WAY_DATA_SIZE_BYTES;
    localparam int AW        = ADDR_W + TAG_W;
    localparam int WORD_LSB  = $clog2(BYTES);
    localparam int BEAT_W    = $clog2(LINE_WORDS);
    localparam int OFF_W     = WORD_LSB + BEAT_W;
    localparam int IDX_W     = ADDR_W - OFF_W;
    localparam int NUM_LINES = 2 ** IDX_W;

    state_t                state;
    logic [AW-1:WORD_LSB]  req_word;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  err;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [BEAT_W-1:0]     req_off;
    logic                  line_valid;
    logic                  hit;
    logic                  accept;
    logic                  beat_wr;
    logic                  beat_err;
    logic                  unused_addr_bits;

    assign req_tag  = req_word[AW-1:ADDR_W];
    assign req_idx  = req_word[ADDR_W-1:OFF_W];
    assign req_off  = req_word[OFF_W-1:WORD_LSB];

    assign unused_addr_bits = ^i_cpu_req_addr[WORD_LSB-1:0];

    assign hit      = line_valid && (i_tag_data == req_tag);
    assign accept   = (state == S_IDLE) && !i_flush && i_cpu_req_valid;
    assign beat_wr  = (state == S_RDATA) && o_axi_rready && i_axi_rvalid;
    assign beat_err = (i_axi_rresp != AXI_RESP_OKAY);

    assign o_cpu_req_ready = (state == S_IDLE) && !i_flush;

    // cache_way has one-cycle read latency, so the lookup address must be
    // presented combinationally in the handshake cycle.
    always_comb begin
        o_cache_way_addr = '0;
        if (accept) begin
            o_cache_way_addr = {i_cpu_req_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
        end else if (state == S_RDATA) begin
            o_cache_way_addr = {req_idx, beat_cnt, {WORD_LSB{1'b0}}};
        end
    end

    assign o_cache_way_wen  = beat_wr;
    assign o_cache_way_ben  = {BYTES{beat_wr}};
    assign o_cache_way_data = beat_wr ? i_axi_rdata : '0;
    assign o_tag_wen        = beat_wr;
    assign o_tag_data       = beat_wr ? req_tag : '0;

    cache_valid_array #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W)
    ) u_valid (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  ((state == S_IDLE) && i_flush),
        .wr_en  (beat_wr && i_axi_rlast),
        .wr_idx (req_idx),
        .wr_val (!(err || beat_err)),
        .rd_idx (req_idx),
        .rd_val (line_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            req_word        <= '0;
            beat_cnt        <= '0;
            err             <= 1'b0;
            o_cpu_rsp_valid <= 1'b0;
            o_cpu_rsp_data  <= '0;
            o_cpu_rsp_err   <= 1'b0;
            o_axi_arvalid   <= 1'b0;
            o_axi_araddr    <= '0;
            o_axi_arlen     <= '0;
            o_axi_arsize    <= '0;
            o_axi_arburst   <= '0;
            o_axi_rready    <= 1'b0;
        end else begin
            o_cpu_rsp_valid <= 1'b0;
            o_cpu_rsp_err   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_word <= i_cpu_req_addr[AW-1:WORD_LSB];
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        o_cpu_rsp_valid <= 1'b1;
                        o_cpu_rsp_data  <= i_cache_way_data;
                        state           <= S_IDLE;
                    end else begin
                        o_axi_arvalid <= 1'b1;
                        o_axi_araddr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        o_axi_arlen   <= 8'(LINE_WORDS - 1);
                        o_axi_arsize  <= axi_size(BYTES);
                        o_axi_arburst <= AXI_BURST_INCR;
                        state         <= S_AR;
                    end
                end
                S_AR: begin
                    if (i_axi_arready) begin
                        o_axi_arvalid <= 1'b0;
                        o_axi_rready  <= 1'b1;
                        beat_cnt      <= '0;
                        err           <= 1'b0;
                        state         <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (i_axi_rvalid) begin
                        // beat_cnt drives addresses; only rlast ends the burst
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == req_off) begin
                            o_cpu_rsp_data <= i_axi_rdata;
                        end
                        if (beat_err) begin
                            err <= 1'b1;
                        end
                        if (i_axi_rlast) begin
                            o_axi_rready    <= 1'b0;
                            o_cpu_rsp_valid <= 1'b1;
                            o_cpu_rsp_err   <= err || beat_err;
                            state           <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl with a cache_way model,
// an AXI read slave driven per scenario and a response scoreboard.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [10:0] cpu_req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flush;
    logic [6:0]  way_addr;
    logic        way_wen;
    logic [3:0]  way_ben;
    logic [31:0] way_wdata;
    logic [31:0] way_rdata;
    logic        tag_wen;
    logic [3:0]  tag_wdata;
    logic [3:0]  tag_rdata;
    logic [10:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_cmp  = 0;
    int n_fail = 0;
    int gen    = 0;

    logic [32:0] exp_q[$];
    logic        model_valid [0:7];
    logic [3:0]  model_tag   [0:7];
    logic [31:0] model_data  [0:31];

    logic [31:0] way_mem [0:31];
    logic [3:0]  tag_mem [0:7];

    cache_refill_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_cpu_req_valid (cpu_req_valid),
        .o_cpu_req_ready (cpu_req_ready),
        .i_cpu_req_addr  (cpu_req_addr),
        .o_cpu_rsp_valid (rsp_valid),
        .o_cpu_rsp_data  (rsp_data),
        .o_cpu_rsp_err   (rsp_err),
        .i_flush         (flush),
        .o_cache_way_addr(way_addr),
        .o_cache_way_wen (way_wen),
        .o_cache_way_ben (way_ben),
        .o_cache_way_data(way_wdata),
        .i_cache_way_data(way_rdata),
        .o_tag_wen       (tag_wen),
        .o_tag_data      (tag_wdata),
        .i_tag_data      (tag_rdata),
        .o_axi_araddr    (araddr),
        .o_axi_arlen     (arlen),
        .o_axi_arsize    (arsize),
        .o_axi_arburst   (arburst),
        .o_axi_arvalid   (arvalid),
        .i_axi_arready   (arready),
        .i_axi_rvalid    (rvalid),
        .o_axi_rready    (rready),
        .i_axi_rdata     (rdata),
        .i_axi_rresp     (rresp),
        .i_axi_rlast     (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cache_way: 1-cycle read latency for data and tag
    always @(posedge clk) begin
        if (way_wen) way_mem[way_addr[6:2]] <= way_wdata;
        if (tag_wen) tag_mem[way_addr[6:4]] <= tag_wdata;
        way_rdata <= way_mem[way_addr[6:2]];
        tag_rdata <= tag_mem[way_addr[6:4]];
    end

    // scoreboard: every response pulse is checked against the oldest expectation
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            logic [32:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%b data=%h, required no response",
                         rsp_err, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_data} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%b data=%h, required err=%b data=%h",
                             rsp_err, rsp_data, e[32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] beat_word(input int g, input logic [10:0] a);
        return 32'hD000_0000 | (32'(g & 255) << 16) | {21'b0, a};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
    endtask

    task automatic run_read(input logic [10:0] addr, input bit exp_hit,
                            input int err_beat, input string name);
        logic [10:0] base;
        logic [31:0] exp_data;
        bit          exp_err;
        bit          ar_seen;
        int          n;
        base = {addr[10:4], 4'b0};
        if (exp_hit) begin
            exp_data = model_data[addr[6:2]];
            exp_err  = 1'b0;
        end else begin
            gen++;
            exp_data = beat_word(gen, base + 11'(4 * addr[3:2]));
            exp_err  = (err_beat >= 0);
        end
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        #1;
        n = 0;
        while (!cpu_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (!cpu_req_ready || way_addr !== {addr[6:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s handshake: got ready=%b way_addr=%h, required ready=1 way_addr=%h",
                     name, cpu_req_ready, way_addr, {addr[6:2], 2'b00});
        end
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        if (exp_hit) begin
            ar_seen = 1'b0;
            n = 1;
            while (!rsp_valid && n < 10) begin
                if (arvalid) ar_seen = 1'b1;
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (n != 2 || ar_seen) begin
                n_fail++;
                $display("FAIL %s hit_timing: got latency=%0d ar=%b, required latency=2 ar=0",
                         name, n, ar_seen);
            end
        end else begin
            n = 0;
            while (!arvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if ({arvalid, araddr, arlen, arsize, arburst} !==
                {1'b1, base, 8'd3, 3'b010, 2'b01}) begin
                n_fail++;
                $display("FAIL %s ar: got v=%b addr=%h len=%0d size=%0d burst=%0d, required v=1 addr=%h len=3 size=2 burst=1",
                         name, arvalid, araddr, arlen, arsize, arburst, base);
                return;
            end
            @(negedge clk);
            n_cmp++;
            if ({arvalid, araddr, arlen} !== {1'b1, base, 8'd3}) begin
                n_fail++;
                $display("FAIL %s ar_hold: got v=%b addr=%h len=%0d, required v=1 addr=%h len=3",
                         name, arvalid, araddr, arlen, base);
            end
            arready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            arready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                rvalid = 1'b1;
                rdata  = beat_word(gen, base + 11'(4 * k));
                rresp  = (k == err_beat) ? 2'b10 : 2'b00;
                rlast  = (k == 3);
                #1;
                n_cmp++;
                if ({rready, way_wen, way_ben, way_addr, way_wdata, tag_wen, tag_wdata} !==
                    {1'b1, 1'b1, 4'hF, 7'(base + 11'(4 * k)), rdata, 1'b1, addr[10:7]}) begin
                    n_fail++;
                    $display("FAIL %s beat%0d: got rready=%b wen=%b ben=%h addr=%h data=%h twen=%b tag=%h, required 1 1 f %h %h 1 %h",
                             name, k, rready, way_wen, way_ben, way_addr, way_wdata, tag_wen,
                             tag_wdata, 7'(base + 11'(4 * k)), rdata, addr[10:7]);
                end
                model_data[base[6:2] + 5'(k)] = rdata;
                @(posedge clk);
                @(negedge clk);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            n = 0;
            while (!rsp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (n != 0) begin
                n_fail++;
                $display("FAIL %s miss_rsp: got rsp after %0d extra cycles, required 0",
                         name, n);
            end
            model_valid[addr[6:4]] = (err_beat < 0);
            model_tag[addr[6:4]]   = addr[10:7];
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_err, arvalid, rready, way_wen, tag_wen} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {rsp_valid, rsp_err, arvalid, rready, way_wen, tag_wen});
        end
        n_cmp++;
        if ({way_addr, araddr, arlen, arsize, arburst, way_ben} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got way=%h ar=%h len=%h size=%h burst=%h ben=%h, required 0",
                     way_addr, araddr, arlen, arsize, arburst, way_ben);
        end
        n_cmp++;
        if ({rsp_data, way_wdata, tag_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rsp=%h way=%h tag=%h, required 0",
                     rsp_data, way_wdata, tag_wdata);
        end
        reset_n = 1'b1;
        clear_model();
    endtask

    task automatic test_cold_miss();
        run_read(11'h014, 1'b0, -1, "cold_miss");
    endtask

    task automatic test_hit();
        run_read(11'h01C, 1'b1, -1, "hit_d3");
        run_read(11'h010, 1'b1, -1, "hit_d0");
    endtask

    task automatic test_conflict();
        run_read(11'h414, 1'b0, -1, "conflict_fill");
        run_read(11'h014, 1'b0, -1, "conflict_refill");
        run_read(11'h018, 1'b1, -1, "conflict_hit");
    endtask

    task automatic test_rresp_err();
        run_read(11'h034, 1'b0, 2, "err_fill");
        run_read(11'h030, 1'b0, -1, "err_refill");
        run_read(11'h038, 1'b1, -1, "err_hit");
    endtask

    task automatic test_flush();
        bit seen;
        run_read(11'h250, 1'b0, -1, "pre_flush_fill");
        run_read(11'h014, 1'b1, -1, "pre_flush_hit");
        @(negedge clk);
        flush         = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 11'h250;
        #1;
        n_cmp++;
        if (cpu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b, required 0", cpu_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        flush         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (arvalid || rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_accept: got activity=1, required 0");
        end
        clear_model();
        run_read(11'h014, 1'b0, -1, "post_flush_014");
        run_read(11'h250, 1'b0, -1, "post_flush_250");
        run_read(11'h030, 1'b0, -1, "post_flush_030");
    endtask

    task automatic test_reset_mid_refill();
        int n;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 11'h024;
        #1;
        n = 0;
        while (!cpu_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hBAD0_0020;
        @(posedge clk);
        @(negedge clk);
        rdata = 32'hBAD0_0024;
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_err, arvalid, rready, way_wen, tag_wen, way_addr, araddr,
             rsp_data, way_wdata, way_ben, tag_wdata} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rsp=%b rr=%b wen=%b twen=%b way=%h ar=%h data=%h, required all 0",
                     rsp_valid, rready, way_wen, tag_wen, way_addr, araddr, rsp_data);
        end
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = '0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
        run_read(11'h024, 1'b0, -1, "after_reset_024");
        run_read(11'h014, 1'b0, -1, "after_reset_014");
        run_read(11'h028, 1'b1, -1, "after_reset_hit");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        flush         = 1'b0;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rdata         = '0;
        rresp         = 2'b00;
        rlast         = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_rresp_err();
        test_flush();
        test_reset_mid_refill();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
